// File: rtl/gtp_pkg.sv
// Shared definitions for the GTP/Aurora framers: control words, CRC seed,
// receive state encoding and the 32-bit-parallel CRC-32 step.
package gtp_pkg;

  localparam logic [31:0] HEAD_W     = 32'h0000_FFBC;
  localparam logic [31:0] END_W      = 32'h0000_FFBD;
  localparam logic [31:0] TRIG_W     = 32'h0000_FFBA;
  localparam logic [31:0] TRIG_END_W = 32'h0000_FFBB;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    S_IDLE, S_GTXID, S_LENGTH, S_DATA, S_CHECK, S_END, S_TRIG_END, S_DROP
  } gtp_state_e;

  // One 32-bit step of CRC-32 (0x04C11DB7), no reflection, data bit 31 enters
  // first. Same result as the unrolled nextCRC32_D32 XOR equations on the TX side.
  function automatic logic [31:0] nextCRC32_D32(input logic [31:0] data,
                                                input logic [31:0] crc);
    logic [31:0] r;
    logic        fb;
    r = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ data[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

endpackage

// File: rtl/gtp_crc32_d32.sv
// Combinational next-CRC wrapper shared by the TX and RX framers.
module gtp_crc32_d32
  import gtp_pkg::*;
(
  input  logic [31:0] data,
  input  logic [31:0] crc,
  output logic [31:0] crc_next
);

  // single 32-bit CRC step
  always_comb crc_next = nextCRC32_D32(data, crc);

endmodule

// File: rtl/gtp_rx.sv
// RX framer for the Aurora user interface: decodes data and trigger frames,
// writes payload to the packet RAM, checks CRC-32 and pulses status.
// Optional build macro RX_GTXID_FILTER_EN: silently drop frames whose GTXID
// differs from local_gtxid.
module gtp_rx
  import gtp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              log_clk,
  input  logic              log_rst_q,
  input  logic [31:0]       m_axi_rx_tdata,
  input  logic              m_axi_rx_tvalid,
  input  logic              m_axi_rx_tlast,
  input  logic [31:0]       local_gtxid,
  output logic              rx_packet_wea,
  output logic [ADDR_W-1:0] rx_packet_addra,
  output logic [31:0]       rx_packet_dina,
  output logic [31:0]       rx_packet_gtxid,
  output logic [31:0]       rx_packet_head,
  output logic              rx_packet_done,
  output logic              rx_crc_err,
  output logic              rx_frame_err,
  output logic              rx_trigger,
  output logic [31:0]       crc_data
);

  gtp_state_e  state_q, state_d;
  logic [31:0] gtxid_sh;
  logic [7:0]  len_q, base_q, idx_q;
  logic        crc_ok_q;
  logic [31:0] crc_next;

  logic        wr_d, done_d, crcerr_d, ferr_d, trig_d;
  logic        gtx_ld, hdr_ld, chk_ld, crc_upd, idx_inc;
  logic [ADDR_W+8:0] addr_sum;
  logic        gtx_mismatch;
  logic [7:0]  n_w;

  gtp_crc32_d32 u_crc (
    .data     (m_axi_rx_tdata),
    .crc      (crc_data),
    .crc_next (crc_next)
  );

  assign n_w      = m_axi_rx_tdata[7:0];
  // base+idx wraps modulo 2^ADDR_W
  assign addr_sum = (ADDR_W+9)'(base_q) + (ADDR_W+9)'(idx_q);

`ifdef RX_GTXID_FILTER_EN
  assign gtx_mismatch = (gtxid_sh != local_gtxid);
`else
  assign gtx_mismatch = 1'b0;
  logic unused_gtxid;
  assign unused_gtxid = ^local_gtxid;
`endif

  // state register
  always_ff @(posedge log_clk) begin
    if (log_rst_q) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // next-state decode and per-beat actions; only accepted beats advance
  always_comb begin
    state_d  = state_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    crcerr_d = 1'b0;
    ferr_d   = 1'b0;
    trig_d   = 1'b0;
    gtx_ld   = 1'b0;
    hdr_ld   = 1'b0;
    chk_ld   = 1'b0;
    crc_upd  = 1'b0;
    idx_inc  = 1'b0;
    if (m_axi_rx_tvalid) begin
      case (state_q)
        S_IDLE: begin
          if (!m_axi_rx_tlast) begin
            if (m_axi_rx_tdata == HEAD_W)      state_d = S_GTXID;
            else if (m_axi_rx_tdata == TRIG_W) state_d = S_TRIG_END;
          end
        end
        S_GTXID: begin
          if (m_axi_rx_tlast) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            gtx_ld  = 1'b1;
            crc_upd = 1'b1;
            state_d = S_LENGTH;
          end
        end
        S_LENGTH: begin
          // a foreign frame is dropped silently, ahead of any length check
          if (gtx_mismatch) begin
            state_d = m_axi_rx_tlast ? S_IDLE : S_DROP;
          end else if (m_axi_rx_tlast) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else if (n_w == 8'd0 || 32'(n_w) > MAX_LEN) begin
            ferr_d  = 1'b1;
            state_d = S_DROP;
          end else begin
            hdr_ld  = 1'b1;
            crc_upd = 1'b1;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (m_axi_rx_tlast) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            wr_d    = 1'b1;
            crc_upd = 1'b1;
            idx_inc = 1'b1;
            if (idx_q + 8'd1 == len_q) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (m_axi_rx_tlast) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            chk_ld  = 1'b1;
            state_d = S_END;
          end
        end
        S_END: begin
          if (m_axi_rx_tlast && m_axi_rx_tdata == END_W) begin
            done_d   = crc_ok_q;
            crcerr_d = !crc_ok_q;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = m_axi_rx_tlast ? S_IDLE : S_DROP;
          end
        end
        S_TRIG_END: begin
          if (m_axi_rx_tlast && m_axi_rx_tdata == TRIG_END_W) begin
            trig_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = m_axi_rx_tlast ? S_IDLE : S_DROP;
          end
        end
        S_DROP: begin
          if (m_axi_rx_tlast) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // CRC register: seeded while idle, stepped on covered beats
  always_ff @(posedge log_clk) begin
    if (log_rst_q || state_q == S_IDLE) crc_data <= CRC_INIT;
    else if (crc_upd)                   crc_data <= crc_next;
  end

  // frame context: shadow GTXID, length/base, word index, CRC verdict
  always_ff @(posedge log_clk) begin
    if (log_rst_q) begin
      gtxid_sh <= '0;
      len_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      if (gtx_ld) gtxid_sh <= m_axi_rx_tdata;
      if (hdr_ld) begin
        len_q  <= n_w;
        base_q <= m_axi_rx_tdata[15:8];
        idx_q  <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 8'd1;
      end
      if (chk_ld) crc_ok_q <= (m_axi_rx_tdata == crc_data);
    end
  end

  // registered RAM write port, header outputs and status pulses
  always_ff @(posedge log_clk) begin
    if (log_rst_q) begin
      rx_packet_wea   <= 1'b0;
      rx_packet_addra <= '0;
      rx_packet_dina  <= '0;
      rx_packet_gtxid <= '0;
      rx_packet_head  <= '0;
      rx_packet_done  <= 1'b0;
      rx_crc_err      <= 1'b0;
      rx_frame_err    <= 1'b0;
      rx_trigger      <= 1'b0;
    end else begin
      rx_packet_wea  <= wr_d;
      rx_packet_done <= done_d;
      rx_crc_err     <= crcerr_d;
      rx_frame_err   <= ferr_d;
      rx_trigger     <= trig_d;
      if (wr_d) begin
        rx_packet_addra <= addr_sum[ADDR_W-1:0];
        rx_packet_dina  <= m_axi_rx_tdata;
      end
      if (hdr_ld) begin
        rx_packet_gtxid <= gtxid_sh;
        rx_packet_head  <= m_axi_rx_tdata;
      end
    end
  end

endmodule

// File: tb/tb_gtp_rx.sv
// Directed bench for gtp_rx: good/bad CRC, trigger, framing errors, address
// wrap with and without tvalid gaps, back-to-back, reset mid-frame, and
// (with RX_GTXID_FILTER_EN) GTXID filtering.
module tb_gtp_rx;

  logic        log_clk = 1'b0;
  logic        log_rst_q = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] local_gtxid = 32'h22;
  logic        wea;
  logic [7:0]  addra;
  logic [31:0] dina, pgtxid, phead, crc_data;
  logic        done, crcerr, ferr, trig;

  gtp_rx #(.ADDR_W(8), .MAX_LEN(255)) dut (
    .log_clk(log_clk), .log_rst_q(log_rst_q),
    .m_axi_rx_tdata(tdata), .m_axi_rx_tvalid(tvalid), .m_axi_rx_tlast(tlast),
    .local_gtxid(local_gtxid),
    .rx_packet_wea(wea), .rx_packet_addra(addra), .rx_packet_dina(dina),
    .rx_packet_gtxid(pgtxid), .rx_packet_head(phead),
    .rx_packet_done(done), .rx_crc_err(crcerr), .rx_frame_err(ferr),
    .rx_trigger(trig), .crc_data(crc_data)
  );

  always #5 log_clk = ~log_clk;

  int pass_cnt = 0, total_cnt = 0;
  int wr_cnt, done_cnt, crcerr_cnt, ferr_cnt, trig_cnt;
  logic [31:0] mem [256];
  logic [7:0]  addr_log [$];
  bit use_gaps = 1'b0;

  // observe registered outputs away from the active edge
  always @(negedge log_clk) begin
    if (wea) begin
      mem[addra] = dina;
      addr_log.push_back(addra);
      wr_cnt++;
    end
    if (done)   done_cnt++;
    if (crcerr) crcerr_cnt++;
    if (ferr)   ferr_cnt++;
    if (trig)   trig_cnt++;
  end

  task automatic clear_obs();
    wr_cnt = 0; done_cnt = 0; crcerr_cnt = 0; ferr_cnt = 0; trig_cnt = 0;
    addr_log.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000;
  endtask

  // reference CRC: seed^data shifted 32 times through the polynomial
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] x;
    x = c ^ d;
    for (int i = 0; i < 32; i++) x = x[31] ? ((x << 1) ^ 32'h04C1_1DB7) : (x << 1);
    return x;
  endfunction

  // one accepted beat; starts and ends at a negedge with tvalid low
  task automatic beat(input logic [31:0] d, input logic l);
    if (use_gaps) repeat ($urandom_range(0, 3)) @(negedge log_clk);
    tvalid = 1'b1; tdata = d; tlast = l;
    @(negedge log_clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // full data frame; tl_at >= 0 puts a premature tlast on that data word
  task automatic send_frame(input logic [31:0] gtxid, input logic [31:0] len,
                            input logic [31:0] dw [8], input logic [31:0] flip,
                            input int tl_at, input int tail);
    logic [31:0] c;
    int n;
    n = int'(len[7:0]);
    c = crc_step(32'hFFFF_FFFF, gtxid);
    c = crc_step(c, len);
    for (int i = 0; i < n; i++) c = crc_step(c, dw[i]);
    beat(32'h0000_FFBC, 1'b0);
    beat(gtxid, 1'b0);
    beat(len, 1'b0);
    for (int i = 0; i < n; i++) begin
      beat(dw[i], i == tl_at);
      if (i == tl_at) begin
        repeat (tail) @(negedge log_clk);
        return;
      end
    end
    beat(c ^ flip, 1'b0);
    beat(32'h0000_FFBD, 1'b1);
    repeat (tail) @(negedge log_clk);
  endtask

  logic [31:0] abc [8] = '{32'hA, 32'hB, 32'hC, 0, 0, 0, 0, 0};
  logic [31:0] w4  [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 0, 0, 0, 0};

  task automatic test_reset();
    log_rst_q = 1'b1;
    repeat (3) @(negedge log_clk);
    total_cnt++; if (crc_data !== 32'hFFFF_FFFF) $display("FAIL reset_crc got %h exp ffffffff", crc_data); else pass_cnt++;
    total_cnt++; if ({wea, done, crcerr, ferr, trig} !== 5'b0) $display("FAIL reset_pulses got %b exp 00000", {wea, done, crcerr, ferr, trig}); else pass_cnt++;
    total_cnt++; if ({addra, dina} !== 40'h0) $display("FAIL reset_wport got %h exp 0", {addra, dina}); else pass_cnt++;
    total_cnt++; if ({pgtxid, phead} !== 64'h0) $display("FAIL reset_hdr got %h exp 0", {pgtxid, phead}); else pass_cnt++;
    log_rst_q = 1'b0;
    @(negedge log_clk);
  endtask

  task automatic test_good_frame();
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h0, -1, 3);
    total_cnt++; if (wr_cnt !== 3) $display("FAIL good_wr_cnt got %0d exp 3", wr_cnt); else pass_cnt++;
    total_cnt++; if ({mem[8'h10], mem[8'h11], mem[8'h12]} !== {32'hA, 32'hB, 32'hC}) $display("FAIL good_mem got %h %h %h exp a b c", mem[8'h10], mem[8'h11], mem[8'h12]); else pass_cnt++;
    total_cnt++; if ({done_cnt, crcerr_cnt, ferr_cnt} !== {32'd1, 32'd0, 32'd0}) $display("FAIL good_pulses got d%0d c%0d f%0d exp 1 0 0", done_cnt, crcerr_cnt, ferr_cnt); else pass_cnt++;
    total_cnt++; if ({pgtxid, phead} !== {32'h11, 32'h0000_1003}) $display("FAIL good_hdr got %h %h exp 11 1003", pgtxid, phead); else pass_cnt++;
    total_cnt++; if (crc_data !== 32'hFFFF_FFFF) $display("FAIL idle_crc got %h exp ffffffff", crc_data); else pass_cnt++;
  endtask

  task automatic test_crc_err();
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h1, -1, 3);
    total_cnt++; if (wr_cnt !== 3 || mem[8'h12] !== 32'hC) $display("FAIL crcerr_writes got %0d/%h exp 3/c", wr_cnt, mem[8'h12]); else pass_cnt++;
    total_cnt++; if ({done_cnt, crcerr_cnt, ferr_cnt} !== {32'd0, 32'd1, 32'd0}) $display("FAIL crcerr_pulses got d%0d c%0d f%0d exp 0 1 0", done_cnt, crcerr_cnt, ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_trigger();
    clear_obs();
    beat(32'h0000_FFBA, 1'b0);
    beat(32'h0000_FFBB, 1'b1);
    repeat (3) @(negedge log_clk);
    total_cnt++; if ({trig_cnt, wr_cnt, ferr_cnt, done_cnt} !== {32'd1, 32'd0, 32'd0, 32'd0}) $display("FAIL trigger got t%0d w%0d f%0d d%0d exp 1 0 0 0", trig_cnt, wr_cnt, ferr_cnt, done_cnt); else pass_cnt++;
  endtask

  task automatic test_early_tlast();
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h0, 1, 3);
    total_cnt++; if ({ferr_cnt, done_cnt, crcerr_cnt} !== {32'd1, 32'd0, 32'd0}) $display("FAIL early_tlast got f%0d d%0d c%0d exp 1 0 0", ferr_cnt, done_cnt, crcerr_cnt); else pass_cnt++;
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h0, -1, 3);
    total_cnt++; if ({done_cnt, ferr_cnt} !== {32'd1, 32'd0}) $display("FAIL after_early got d%0d f%0d exp 1 0", done_cnt, ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_bad_len();
    clear_obs();
    beat(32'h0000_FFBC, 1'b0);
    beat(32'h33, 1'b0);
    beat(32'h0000_0500, 1'b0);   // N=0
    beat(32'h0000_FFBC, 1'b0);   // dropped, not a new HEAD
    beat(32'h0000_FFBD, 1'b1);
    repeat (3) @(negedge log_clk);
    total_cnt++; if ({ferr_cnt, wr_cnt, done_cnt} !== {32'd1, 32'd0, 32'd0}) $display("FAIL bad_len got f%0d w%0d d%0d exp 1 0 0", ferr_cnt, wr_cnt, done_cnt); else pass_cnt++;
    total_cnt++; if (pgtxid !== 32'h11) $display("FAIL bad_len_hdr got %h exp 11", pgtxid); else pass_cnt++;
    clear_obs();
    beat(32'h0000_FFBA, 1'b0);
    beat(32'h0000_FFBD, 1'b1);   // wrong trigger end
    repeat (3) @(negedge log_clk);
    total_cnt++; if ({ferr_cnt, trig_cnt} !== {32'd1, 32'd0}) $display("FAIL bad_trig_end got f%0d t%0d exp 1 0", ferr_cnt, trig_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap(input bit gaps);
    use_gaps = gaps;
    clear_obs();
    send_frame(32'h11, 32'h0000_FE04, w4, 32'h0, -1, 4);
    use_gaps = 1'b0;
    total_cnt++;
    if (addr_log.size() != 4 || addr_log[0] !== 8'hFE || addr_log[1] !== 8'hFF || addr_log[2] !== 8'h00 || addr_log[3] !== 8'h01)
      $display("FAIL wrap_addr gaps=%0d got n=%0d exp fe ff 00 01", gaps, addr_log.size());
    else pass_cnt++;
    total_cnt++; if ({mem[8'hFE], mem[8'h01]} !== {32'h1111_0001, 32'h4444_0004}) $display("FAIL wrap_data gaps=%0d got %h %h", gaps, mem[8'hFE], mem[8'h01]); else pass_cnt++;
    total_cnt++; if ({done_cnt, crcerr_cnt, ferr_cnt} !== {32'd1, 32'd0, 32'd0}) $display("FAIL wrap_pulses gaps=%0d got d%0d c%0d f%0d exp 1 0 0", gaps, done_cnt, crcerr_cnt, ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h0, -1, 0);
    beat(32'h0000_FFBA, 1'b0);
    beat(32'h0000_FFBB, 1'b1);
    send_frame(32'h11, 32'h0000_FE04, w4, 32'h0, -1, 3);
    total_cnt++; if ({done_cnt, trig_cnt, wr_cnt, ferr_cnt} !== {32'd2, 32'd1, 32'd7, 32'd0}) $display("FAIL b2b got d%0d t%0d w%0d f%0d exp 2 1 7 0", done_cnt, trig_cnt, wr_cnt, ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    clear_obs();
    beat(32'h0000_FFBC, 1'b0);
    beat(32'h11, 1'b0);
    beat(32'h0000_2003, 1'b0);
    beat(32'h5, 1'b0);
    log_rst_q = 1'b1;
    @(negedge log_clk);
    log_rst_q = 1'b0;
    total_cnt++; if (crc_data !== 32'hFFFF_FFFF || wea !== 1'b0) $display("FAIL midrst_state got crc %h wea %b exp ffffffff 0", crc_data, wea); else pass_cnt++;
    repeat (2) @(negedge log_clk);
    total_cnt++; if ({wr_cnt, done_cnt, crcerr_cnt, ferr_cnt} !== {32'd1, 32'd0, 32'd0, 32'd0}) $display("FAIL midrst_pulses got w%0d d%0d c%0d f%0d exp 1 0 0 0", wr_cnt, done_cnt, crcerr_cnt, ferr_cnt); else pass_cnt++;
    clear_obs();
    send_frame(32'h11, 32'h0000_1003, abc, 32'h0, -1, 3);
    total_cnt++; if (done_cnt !== 1) $display("FAIL midrst_recover got %0d exp 1", done_cnt); else pass_cnt++;
  endtask

`ifdef RX_GTXID_FILTER_EN
  task automatic test_filter();
    logic [31:0] g0;
    g0 = pgtxid;
    clear_obs();
    send_frame(32'h11, 32'h0000_3003, abc, 32'h0, -1, 3);
    total_cnt++; if ({wr_cnt, done_cnt, crcerr_cnt, ferr_cnt} !== 128'h0) $display("FAIL filter_drop got w%0d d%0d c%0d f%0d exp 0 0 0 0", wr_cnt, done_cnt, crcerr_cnt, ferr_cnt); else pass_cnt++;
    total_cnt++; if (pgtxid !== g0) $display("FAIL filter_hdr got %h exp %h", pgtxid, g0); else pass_cnt++;
    clear_obs();
    send_frame(32'h22, 32'h0000_3003, abc, 32'h0, -1, 3);
    total_cnt++; if ({done_cnt, wr_cnt} !== {32'd1, 32'd3}) $display("FAIL filter_pass got d%0d w%0d exp 1 3", done_cnt, wr_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    clear_obs();
    test_reset();
    test_good_frame();
    test_crc_err();
    test_trigger();
    test_early_tlast();
    test_bad_len();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_back_to_back();
    test_mid_reset();
`ifdef RX_GTXID_FILTER_EN
    test_filter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // hard stop so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
